mem_stage: RTL

- Memory/writeback stage directly downstream of the 16-bit ALU in the multi-cycle CPU.
- Consumes the ALU result, zero flag and opcode. Uses the result as the data-memory address for `ldr`/`str`, and runs a request/acknowledge handshake with data memory.
- Produces a registered writeback bundle for the register file, plus the branch-taken indication for `beq`.
- Opcode encodings come from macro_defines.v.

---
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory/writeback stage after the ALU: ALU ops retire in 1 cycle, ldr/str run a
// req/ack access with timeout. in_ready drops for the whole access.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] store_data,
  input  logic [RD_W-1:0]   rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic              mem_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_LDR  = 4'd11;
  localparam logic [3:0] OP_STR  = 4'd12;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                is_ldr_q, is_ldr_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_en_q, wb_en_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                branch_q, branch_d;
  logic                err_q, err_d;
  logic                alu_wr;

  // Register-writing ALU ops; beq and unknown opcodes retire without a write.
  always_comb begin
    alu_wr = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SLT, OP_LSL, OP_LSR: alu_wr = 1'b1;
      default:                                alu_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_ldr_d    = is_ldr_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    branch_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_LDR || op == OP_STR) begin
            state_d     = ACCESS;
            cnt_d       = 8'd0;
            is_ldr_d    = (op == OP_LDR);
            rd_d        = rd;
            mem_req_d   = 1'b1;
            mem_we_d    = (op == OP_STR);
            mem_addr_d  = alu_out;
            mem_wdata_d = (op == OP_STR) ? store_data : '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_en_d    = alu_wr;
            wb_rd_d    = rd;
            wb_data_d  = alu_out;
            branch_d   = (op == OP_BEQ) && alu_zero;
          end
        end
      end
      ACCESS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_en_d    = is_ldr_q;
          wb_rd_d    = rd_q;
          wb_data_d  = is_ldr_q ? mem_rdata : '0;
        end else if (cnt_q == TMO) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      is_ldr_q    <= 1'b0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      branch_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_ldr_q    <= is_ldr_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      branch_q    <= branch_d;
      err_q       <= err_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign branch_taken = branch_q;
  assign mem_err      = err_q;

endmodule
